// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU and branch resolution, feeding the EX/MEM register.
// One cycle from the *_d2 bundle to the *_d3 outputs; stall holds EX/MEM and flush loads a bubble.
module ex_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_d2,
    input  logic [XLEN-1:0] rs1_data_d2,
    input  logic [XLEN-1:0] rs2_data_d2,
    input  logic [4:0]      rs1_d2,
    input  logic [4:0]      rs2_d2,
    input  logic [4:0]      rd_d2,
    input  logic [XLEN-1:0] immediate_d2,
    input  logic            branch_d2,
    input  logic            mem_read_d2,
    input  logic            mem_to_reg_d2,
    input  logic            mem_write_d2,
    input  logic            alu_src_d2,
    input  logic            reg_write_d2,
    input  logic [1:0]      alu_op_d2,
    input  logic [2:0]      func3_d2,
    input  logic            func7b5_d2,
    input  logic [4:0]      memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_data,
    input  logic            stall,
    input  logic            flush,
    output logic [XLEN-1:0] alu_result_d3,
    output logic [XLEN-1:0] store_data_d3,
    output logic [4:0]      rd_d3,
    output logic [2:0]      func3_d3,
    output logic            mem_read_d3,
    output logic            mem_write_d3,
    output logic            mem_to_reg_d3,
    output logic            reg_write_d3,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target
);

    logic [XLEN-1:0] alu_result_q, alu_result_d;
    logic [XLEN-1:0] store_data_q, store_data_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      func3_q, func3_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;
    logic            mem_to_reg_q, mem_to_reg_d;
    logic            reg_write_q, reg_write_d;

    logic [XLEN-1:0] fwd_a, fwd_b, alu_b, alu_res;
    logic [5:0]      shamt;
    logic            lt_s, lt_u, eq, cond;

    // A load sitting in EX/MEM has no data yet, so it is excluded from forwarding.
    always_comb begin
        fwd_a = rs1_data_d2;
        if (reg_write_q && !mem_read_q && rd_q != 5'd0 && rd_q == rs1_d2)
            fwd_a = alu_result_q;
        else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs1_d2)
            fwd_a = memwb_data;

        fwd_b = rs2_data_d2;
        if (reg_write_q && !mem_read_q && rd_q != 5'd0 && rd_q == rs2_d2)
            fwd_b = alu_result_q;
        else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs2_d2)
            fwd_b = memwb_data;
    end

    assign alu_b = alu_src_d2 ? immediate_d2 : fwd_b;
    assign shamt = alu_b[5:0];

    always_comb begin
        alu_res = fwd_a + alu_b;
        case (alu_op_d2)
            2'b00: alu_res = fwd_a + alu_b;
            2'b01: alu_res = fwd_a - alu_b;
            default: begin
                case (func3_d2)
                    3'b000: alu_res = (alu_op_d2 == 2'b10 && func7b5_d2) ? fwd_a - alu_b
                                                                        : fwd_a + alu_b;
                    3'b001: alu_res = fwd_a << shamt;
                    3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(alu_b)};
                    3'b011: alu_res = {{(XLEN-1){1'b0}}, fwd_a < alu_b};
                    3'b100: alu_res = fwd_a ^ alu_b;
                    3'b101: alu_res = func7b5_d2 ? XLEN'($signed(fwd_a) >>> shamt)
                                                 : fwd_a >> shamt;
                    3'b110: alu_res = fwd_a | alu_b;
                    default: alu_res = fwd_a & alu_b;
                endcase
            end
        endcase
    end

    // Branches always compare the two register operands, never the immediate.
    assign eq   = (fwd_a == fwd_b);
    assign lt_s = ($signed(fwd_a) < $signed(fwd_b));
    assign lt_u = (fwd_a < fwd_b);

    always_comb begin
        case (func3_d2)
            3'b000:  cond = eq;
            3'b001:  cond = !eq;
            3'b100:  cond = lt_s;
            3'b101:  cond = !lt_s;
            3'b110:  cond = lt_u;
            3'b111:  cond = !lt_u;
            default: cond = 1'b0;
        endcase
    end

    // Suppressed while stalled so a held branch redirects fetch only once.
    assign branch_taken  = branch_d2 & cond & ~stall & ~rst;
    assign branch_target = pc_d2 + immediate_d2;

    always_comb begin
        alu_result_d = alu_result_q;
        store_data_d = store_data_q;
        rd_d         = rd_q;
        func3_d      = func3_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        reg_write_d  = reg_write_q;
        if (flush) begin
            alu_result_d = '0;
            store_data_d = '0;
            rd_d         = '0;
            func3_d      = '0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            reg_write_d  = 1'b0;
        end else if (!stall) begin
            alu_result_d = alu_res;
            store_data_d = fwd_b;
            rd_d         = rd_d2;
            func3_d      = func3_d2;
            mem_read_d   = mem_read_d2;
            mem_write_d  = mem_write_d2;
            mem_to_reg_d = mem_to_reg_d2;
            reg_write_d  = reg_write_d2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_q <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
            func3_q      <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
        end else begin
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            rd_q         <= rd_d;
            func3_q      <= func3_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
        end
    end

    assign alu_result_d3 = alu_result_q;
    assign store_data_d3 = store_data_q;
    assign rd_d3         = rd_q;
    assign func3_d3      = func3_q;
    assign mem_read_d3   = mem_read_q;
    assign mem_write_d3  = mem_write_q;
    assign mem_to_reg_d3 = mem_to_reg_q;
    assign reg_write_d3  = reg_write_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU/branch vector table plus forwarding, stall and flush sequences.
module tb_ex_stage;

    localparam int XLEN = 64;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] pc_d2, rs1_data_d2, rs2_data_d2, immediate_d2;
    logic [4:0]      rs1_d2, rs2_d2, rd_d2;
    logic            branch_d2, mem_read_d2, mem_to_reg_d2, mem_write_d2, alu_src_d2, reg_write_d2;
    logic [1:0]      alu_op_d2;
    logic [2:0]      func3_d2;
    logic            func7b5_d2;
    logic [4:0]      memwb_rd;
    logic            memwb_reg_write;
    logic [XLEN-1:0] memwb_data;
    logic            stall, flush;
    logic [XLEN-1:0] alu_result_d3, store_data_d3, branch_target;
    logic [4:0]      rd_d3;
    logic [2:0]      func3_d3;
    logic            mem_read_d3, mem_write_d3, mem_to_reg_d3, reg_write_d3, branch_taken;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .pc_d2(pc_d2), .rs1_data_d2(rs1_data_d2), .rs2_data_d2(rs2_data_d2),
        .rs1_d2(rs1_d2), .rs2_d2(rs2_d2), .rd_d2(rd_d2), .immediate_d2(immediate_d2),
        .branch_d2(branch_d2), .mem_read_d2(mem_read_d2), .mem_to_reg_d2(mem_to_reg_d2),
        .mem_write_d2(mem_write_d2), .alu_src_d2(alu_src_d2), .reg_write_d2(reg_write_d2),
        .alu_op_d2(alu_op_d2), .func3_d2(func3_d2), .func7b5_d2(func7b5_d2),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_data(memwb_data),
        .stall(stall), .flush(flush),
        .alu_result_d3(alu_result_d3), .store_data_d3(store_data_d3), .rd_d3(rd_d3),
        .func3_d3(func3_d3), .mem_read_d3(mem_read_d3), .mem_write_d3(mem_write_d3),
        .mem_to_reg_d3(mem_to_reg_d3), .reg_write_d3(reg_write_d3),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    typedef struct {
        logic [63:0] a, b, imm, pc;
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        f7, src, br;
        logic [63:0] exp_res;
        logic        exp_tk;
        logic [63:0] exp_tgt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear();
        pc_d2 = '0; rs1_data_d2 = '0; rs2_data_d2 = '0; immediate_d2 = '0;
        rs1_d2 = 5'd1; rs2_d2 = 5'd2; rd_d2 = 5'd0;
        branch_d2 = 0; mem_read_d2 = 0; mem_to_reg_d2 = 0; mem_write_d2 = 0;
        alu_src_d2 = 0; reg_write_d2 = 0; alu_op_d2 = 2'b00; func3_d2 = 3'b000; func7b5_d2 = 0;
        memwb_rd = 5'd0; memwb_reg_write = 0; memwb_data = '0;
        stall = 0; flush = 0;
    endtask

    initial begin
        //            a      b     imm    pc     op     f3     f7 src br  exp_res        tk  tgt
        vecs.push_back('{64'd10, 64'd3, 64'd0, 64'd0, 2'b10, 3'b000, 1, 0, 0, 64'd7, 0, 64'd0});
        vecs.push_back('{64'd10, 64'd3, 64'd0, 64'd0, 2'b10, 3'b000, 0, 0, 0, 64'd13, 0, 64'd0});
        vecs.push_back('{64'd10, 64'd3, 64'd5, 64'd0, 2'b11, 3'b000, 1, 1, 0, 64'd15, 0, 64'd0});
        vecs.push_back('{ONES, 64'd1, 64'd0, 64'd0, 2'b00, 3'b000, 0, 0, 0, 64'd0, 0, 64'd0});
        vecs.push_back('{64'd5, 64'd7, 64'd0, 64'd0, 2'b01, 3'b000, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 64'd0});
        vecs.push_back('{ONES, 64'd1, 64'd0, 64'd0, 2'b10, 3'b010, 0, 0, 0, 64'd1, 0, 64'd0});
        vecs.push_back('{ONES, 64'd1, 64'd0, 64'd0, 2'b10, 3'b011, 0, 0, 0, 64'd0, 0, 64'd0});
        vecs.push_back('{64'hF0, 64'h0F, 64'd0, 64'd0, 2'b10, 3'b100, 0, 0, 0, 64'hFF, 0, 64'd0});
        vecs.push_back('{64'hF0, 64'h0F, 64'd0, 64'd0, 2'b10, 3'b110, 0, 0, 0, 64'hFF, 0, 64'd0});
        vecs.push_back('{64'hFF, 64'h3C, 64'd0, 64'd0, 2'b10, 3'b111, 0, 0, 0, 64'h3C, 0, 64'd0});
        vecs.push_back('{MSB, 64'd63, 64'd0, 64'd0, 2'b10, 3'b101, 1, 0, 0, ONES, 0, 64'd0});
        vecs.push_back('{MSB, 64'd63, 64'd0, 64'd0, 2'b10, 3'b101, 0, 0, 0, 64'd1, 0, 64'd0});
        vecs.push_back('{64'd5, 64'd64, 64'd0, 64'd0, 2'b10, 3'b001, 0, 0, 0, 64'd5, 0, 64'd0});
        vecs.push_back('{64'd1, 64'd4, 64'd0, 64'd0, 2'b10, 3'b001, 0, 0, 0, 64'd16, 0, 64'd0});
        vecs.push_back('{MSB, 64'd0, 64'd64, 64'd0, 2'b11, 3'b101, 1, 1, 0, MSB, 0, 64'd0});
        vecs.push_back('{ONES, 64'd0, 64'd1, 64'd0, 2'b11, 3'b010, 0, 1, 0, 64'd1, 0, 64'd0});
        // Branches: alu_op 01 gives A-B in the result.
        vecs.push_back('{ONES, 64'd1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h100, 2'b01, 3'b100, 0, 0, 1,
                         64'hFFFF_FFFF_FFFF_FFFE, 1, 64'hF8});
        vecs.push_back('{ONES, 64'd1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h100, 2'b01, 3'b110, 0, 0, 1,
                         64'hFFFF_FFFF_FFFF_FFFE, 0, 64'hF8});
        vecs.push_back('{64'd5, 64'd5, 64'h20, 64'h1000, 2'b01, 3'b000, 0, 0, 1, 64'd0, 1, 64'h1020});
        vecs.push_back('{64'd5, 64'd5, 64'h20, 64'h1000, 2'b01, 3'b001, 0, 0, 1, 64'd0, 0, 64'h1020});
        vecs.push_back('{ONES, 64'd1, 64'h8, ONES, 2'b01, 3'b101, 0, 0, 1,
                         64'hFFFF_FFFF_FFFF_FFFE, 0, 64'h7});
        vecs.push_back('{ONES, 64'd1, 64'h4, 64'h0, 2'b01, 3'b111, 0, 0, 1,
                         64'hFFFF_FFFF_FFFF_FFFE, 1, 64'h4});
        vecs.push_back('{64'd3, 64'd1, 64'h4, 64'h0, 2'b01, 3'b010, 0, 0, 1, 64'd2, 0, 64'h4});

        // Reset: registers cleared and branch_taken forced low even with a true BEQ.
        clear();
        rst = 1;
        branch_d2 = 1; alu_op_d2 = 2'b01;
        @(negedge clk);
        step();
        #1;
        chk("rst_alu_result", alu_result_d3, 64'd0);
        chk("rst_store_data", store_data_d3, 64'd0);
        chk("rst_rd", {59'd0, rd_d3}, 64'd0);
        chk("rst_func3", {61'd0, func3_d3}, 64'd0);
        chk("rst_ctrls", {60'd0, mem_read_d3, mem_write_d3, mem_to_reg_d3, reg_write_d3}, 64'd0);
        chk("rst_branch_taken", {63'd0, branch_taken}, 64'd0);
        rst = 0;
        clear();

        foreach (vecs[i]) begin
            rs1_data_d2 = vecs[i].a; rs2_data_d2 = vecs[i].b; immediate_d2 = vecs[i].imm;
            pc_d2 = vecs[i].pc; alu_op_d2 = vecs[i].op; func3_d2 = vecs[i].f3;
            func7b5_d2 = vecs[i].f7; alu_src_d2 = vecs[i].src; branch_d2 = vecs[i].br;
            #1;
            chk($sformatf("v%0d_taken", i), {63'd0, branch_taken}, {63'd0, vecs[i].exp_tk});
            if (vecs[i].br) chk($sformatf("v%0d_target", i), branch_target, vecs[i].exp_tgt);
            step();
            chk($sformatf("v%0d_result", i), alu_result_d3, vecs[i].exp_res);
            chk($sformatf("v%0d_store", i), store_data_d3, vecs[i].b);
        end
        clear();

        // Forwarding: EX/MEM (rd=5, 0x40) beats MEM/WB (rd=5, 0x99).
        rs1_d2 = 5'd0; rs1_data_d2 = 64'h40; alu_op_d2 = 2'b11; alu_src_d2 = 1;
        rd_d2 = 5'd5; reg_write_d2 = 1;
        step();
        rs1_d2 = 5'd5; rs1_data_d2 = 64'h1234; immediate_d2 = 64'd1; rd_d2 = 5'd6;
        memwb_rd = 5'd5; memwb_reg_write = 1; memwb_data = 64'h99;
        step();
        chk("fwd_exmem_wins", alu_result_d3, 64'h41);
        // EX/MEM now rd=6, so MEM/WB supplies x5.
        step();
        chk("fwd_memwb", alu_result_d3, 64'h9A);
        // Store reading x6 from EX/MEM via operand B.
        rs1_d2 = 5'd0; rs1_data_d2 = 64'h0; rs2_d2 = 5'd6; rs2_data_d2 = 64'h0;
        immediate_d2 = 64'd8; reg_write_d2 = 0; mem_write_d2 = 1; rd_d2 = 5'd0;
        memwb_reg_write = 0;
        step();
        chk("fwd_store_data", store_data_d3, 64'h9A);
        chk("store_mem_write", {63'd0, mem_write_d3}, 64'd1);
        // Load in EX/MEM with rd=5 must not be forwarded.
        clear();
        rd_d2 = 5'd5; reg_write_d2 = 1; mem_read_d2 = 1; mem_to_reg_d2 = 1;
        rs1_data_d2 = 64'h500; alu_op_d2 = 2'b00; alu_src_d2 = 1; func3_d2 = 3'b011;
        step();
        chk("load_func3", {61'd0, func3_d3}, 64'd3);
        chk("load_ctrls", {60'd0, mem_read_d3, mem_write_d3, mem_to_reg_d3, reg_write_d3}, 64'b1011);
        clear();
        rs1_d2 = 5'd5; rs1_data_d2 = 64'h7; immediate_d2 = 64'd1; alu_op_d2 = 2'b11; alu_src_d2 = 1;
        step();
        chk("no_fwd_from_load", alu_result_d3, 64'h8);
        // rd=0 in both stages: raw register value.
        clear();
        rs1_d2 = 5'd3; rs1_data_d2 = 64'h40; alu_op_d2 = 2'b11; alu_src_d2 = 1;
        rd_d2 = 5'd0; reg_write_d2 = 1;
        step();
        rs1_d2 = 5'd0; rs1_data_d2 = 64'h7; immediate_d2 = 64'd1;
        memwb_rd = 5'd0; memwb_reg_write = 1; memwb_data = 64'h99;
        step();
        chk("x0_no_fwd", alu_result_d3, 64'h8);

        // Stall: load a known instruction, then hold for three cycles with changing inputs.
        clear();
        rs1_data_d2 = 64'h1111; rs2_data_d2 = 64'h2222; alu_op_d2 = 2'b00;
        rd_d2 = 5'd7; reg_write_d2 = 1; mem_write_d2 = 1; func3_d2 = 3'b010;
        step();
        stall = 1;
        for (int c = 0; c < 3; c++) begin
            rs1_data_d2 = 64'(c * 100 + 5); rs2_data_d2 = 64'(c + 9); rd_d2 = 5'(c + 10);
            reg_write_d2 = 0; mem_write_d2 = 0; func3_d2 = 3'b000;
            branch_d2 = 1; alu_op_d2 = 2'b01; rs2_data_d2 = rs1_data_d2;
            #1;
            chk($sformatf("stall%0d_no_redirect", c), {63'd0, branch_taken}, 64'd0);
            step();
            chk($sformatf("stall%0d_result", c), alu_result_d3, 64'h3333);
            chk($sformatf("stall%0d_rd", c), {59'd0, rd_d3}, 64'd7);
            chk($sformatf("stall%0d_ctrls", c),
                {60'd0, mem_read_d3, mem_write_d3, mem_to_reg_d3, reg_write_d3}, 64'b0101);
        end
        flush = 1;
        step();
        chk("flush_reg_write", {63'd0, reg_write_d3}, 64'd0);
        chk("flush_mem_write", {63'd0, mem_write_d3}, 64'd0);
        chk("flush_result", alu_result_d3, 64'd0);
        chk("flush_rd", {59'd0, rd_d3}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
